// File: rtl/onehot_codec_stream.sv
// Registered binary<->one-hot codec behind a valid/ready stream, with a saturating
// count of invalid one-hot codes seen in decode mode.
module onehot_codec_stream #(
    parameter  int BIN_W     = 4,
    parameter  int ERR_CNT_W = 8,
    localparam int OH_W      = 2**BIN_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OH_W-1:0]      in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OH_W-1:0]      out_onehot,
    output logic [BIN_W-1:0]     out_bin,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count,
    input  logic                 err_clr
);

    // Handshake: a word moves on a rising edge where valid & ready are both high;
    // out_* hold while out_valid & !out_ready, and in_ready is low during reset.
    logic                 out_valid_q, out_valid_d;
    logic [OH_W-1:0]      out_onehot_q, out_onehot_d;
    logic [BIN_W-1:0]     out_bin_q, out_bin_d;
    logic                 out_err_q, out_err_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    logic                 accept;
    logic [OH_W-1:0]      lowest;
    logic                 multi;
    logic [BIN_W-1:0]     low_idx;
    logic [BIN_W-1:0]     enc_idx;
    logic [OH_W-1:0]      res_onehot;
    logic [BIN_W-1:0]     res_bin;
    logic                 res_err;
    logic                 count_err;

    always_comb begin
        in_ready = !rst && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;

        // Two's-complement trick isolates the lowest set bit; a nonzero
        // remainder after clearing it means more than one bit was set.
        lowest  = in_data & (~in_data + OH_W'(1));
        multi   = |(in_data & (in_data - OH_W'(1)));
        low_idx = '0;
        for (int i = OH_W - 1; i >= 0; i--) begin
            if (in_data[i]) low_idx = BIN_W'(i);
        end
        enc_idx = in_data[BIN_W-1:0];

        if (mode) begin
            res_onehot = lowest;
            res_bin    = low_idx;
            res_err    = (in_data == '0) || multi;
        end else begin
            res_onehot = OH_W'(1) << enc_idx;
            res_bin    = enc_idx;
            res_err    = 1'b0;
        end

        out_valid_d  = out_valid_q;
        out_onehot_d = out_onehot_q;
        out_bin_d    = out_bin_q;
        out_err_d    = out_err_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_onehot_d = res_onehot;
            out_bin_d    = res_bin;
            out_err_d    = res_err;
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end

        // A clear coinciding with a counted error leaves the count at 1.
        count_err   = accept && mode && res_err;
        err_count_d = err_count_q;
        if (err_clr) begin
            err_count_d = count_err ? ERR_CNT_W'(1) : '0;
        end else if (count_err && !(&err_count_q)) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_onehot_q <= '0;
            out_bin_q    <= '0;
            out_err_q    <= 1'b0;
            err_count_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_onehot_q <= out_onehot_d;
            out_bin_q    <= out_bin_d;
            out_err_q    <= out_err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_onehot = out_onehot_q;
    assign out_bin    = out_bin_q;
    assign out_err    = out_err_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_onehot_codec_stream.sv
// Scoreboard bench for onehot_codec_stream: main 4-bit instance plus a 2-bit
// error-counter instance and a 3-bit binary instance for the boundary cases.
module tb_onehot_codec_stream;

    localparam int EXP_W = 21;

    logic        clk;
    logic        rst;
    logic        mode, in_valid, in_ready, out_valid, out_ready, out_err, err_clr;
    logic [15:0] in_data, out_onehot;
    logic [3:0]  out_bin;
    logic [7:0]  err_count;

    logic        mode2, in_valid2, in_ready2, out_valid2, out_ready2, out_err2, err_clr2;
    logic [15:0] in_data2, out_onehot2;
    logic [3:0]  out_bin2;
    logic [1:0]  err_count2;

    logic        mode3, in_valid3, in_ready3, out_valid3, out_ready3, out_err3, err_clr3;
    logic [7:0]  in_data3, out_onehot3;
    logic [2:0]  out_bin3;
    logic [7:0]  err_count3;

    logic [EXP_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int exp_errs = 0;
    int exp2 = 0;
    logic rand_bp = 1'b0;

    onehot_codec_stream #(.BIN_W(4), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_onehot(out_onehot), .out_bin(out_bin), .out_err(out_err),
        .err_count(err_count), .err_clr(err_clr)
    );

    onehot_codec_stream #(.BIN_W(4), .ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .mode(mode2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_onehot(out_onehot2), .out_bin(out_bin2), .out_err(out_err2),
        .err_count(err_count2), .err_clr(err_clr2)
    );

    onehot_codec_stream #(.BIN_W(3), .ERR_CNT_W(8)) dut3 (
        .clk(clk), .rst(rst), .mode(mode3), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_data(in_data3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_onehot(out_onehot3), .out_bin(out_bin3), .out_err(out_err3),
        .err_count(err_count3), .err_clr(err_clr3)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Result packed as {onehot[15:0], bin[3:0], err}.
    function automatic logic [EXP_W-1:0] model(input logic m, input logic [15:0] d);
        int ones, idx;
        logic [15:0] oh;
        logic [3:0]  b;
        logic        e;
        if (!m) begin
            idx = int'(d) % 16;
            oh  = 16'(2**idx);
            b   = 4'(idx);
            e   = 1'b0;
        end else begin
            ones = $countones(d);
            if (ones == 0) begin
                oh = '0; b = '0; e = 1'b1;
            end else begin
                idx = 0;
                while (((int'(d) >> idx) % 2) == 0) idx++;
                oh = 16'(2**idx);
                b  = 4'(idx);
                e  = (ones != 1);
            end
        end
        return {oh, b, e};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic send(input logic m, input logic [15:0] d, output int waits);
        logic ok;
        logic [EXP_W-1:0] r;
        ok = 1'b0;
        waits = 0;
        in_valid = 1'b1;
        mode = m;
        in_data = d;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else waits++;
        end
        if (ok) begin
            r = model(m, d);
            exp_q.push_back(r);
            if (m && r[0] && exp_errs < 255) exp_errs++;
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready never rose for data %0h", d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (!out_valid && exp_q.size() == 0) done = 1'b0 | 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: out_valid=%0d queued=%0d", out_valid, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- random backpressure ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [EXP_W-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: onehot %0h with empty queue", out_onehot);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_onehot", 32'(out_onehot), 32'(e[20:5]));
                    chk("out_bin", 32'(out_bin), 32'(e[4:1]));
                    chk("out_err", 32'(out_err), 32'(e[0]));
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int w;
        logic [15:0] d;
        logic m;
        int sel;

        rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; err_clr = 1'b0;
        mode2 = 1'b1; in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1; err_clr2 = 1'b0;
        mode3 = 1'b0; in_valid3 = 1'b0; in_data3 = '0; out_ready3 = 1'b1; err_clr3 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_out_onehot", 32'(out_onehot), 0);
        chk("reset_out_bin", 32'(out_bin), 0);
        chk("reset_out_err", 32'(out_err), 0);
        chk("reset_err_count", 32'(err_count), 0);
        chk("reset_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Encode sweep, back-to-back
        for (int i = 0; i < 16; i++) begin
            send(1'b0, 16'(i), w);
            chk("sweep_no_stall", 32'(w), 0);
            chk("sweep_out_valid", 32'(out_valid), 1);
        end
        drain();

        // Directed decodes
        send(1'b1, 16'h0100, w);
        send(1'b1, 16'h0000, w);
        send(1'b1, 16'h0A00, w);
        drain();
        chk("decode_err_count", 32'(err_count), 2);
        chk("decode_err_model", 32'(err_count), 32'(exp_errs));

        // Reset while a word is pending and err_count=2
        out_ready = 1'b0;
        send(1'b0, 16'h0003, w);
        rst = 1'b1;
        in_valid = 1'b1; mode = 1'b1; in_data = 16'h0000;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        exp_q.delete();
        exp_errs = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", 32'(out_valid), 0);
        chk("post_rst_err_count", 32'(err_count), 0);
        chk("post_rst_out_onehot", 32'(out_onehot), 0);
        @(posedge clk);
        #1;

        // Backpressure hold
        drain();
        out_ready = 1'b0;
        send(1'b0, 16'h0005, w);
        in_valid = 1'b1; mode = 1'b0; in_data = 16'h0006;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_out_onehot", 32'(out_onehot), 32'h0020);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(in_ready), 1);
        exp_q.push_back(model(1'b0, 16'h0006));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_next_word", 32'(out_onehot), 32'h0040);
        drain();

        // Randomized traffic with random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 80; i++) begin
            m = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 3);
            case (sel)
                0, 3:    d = 16'h0001 << $urandom_range(0, 15);
                1:       d = 16'h0000;
                default: d = 16'($urandom);
            endcase
            send(m, d, w);
        end
        rand_bp = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
        chk("random_queue_empty", 32'(exp_q.size()), 0);
        chk("random_err_count", 32'(err_count), 32'(exp_errs));

        // Idle clear
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        exp_errs = 0;
        chk("err_clr_idle", 32'(err_count), 32'(exp_errs));

        // 2-bit counter saturation, then clear with concurrent error
        in_valid2 = 1'b1;
        mode2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data2 = (i % 2 == 1) ? 16'h0000 : 16'h0003;
            @(posedge clk);
            #1;
            exp2 = (exp2 + 1 > 3) ? 3 : exp2 + 1;
            chk("sat_err_count", 32'(err_count2), 32'(exp2));
        end
        err_clr2 = 1'b1;
        in_data2 = 16'h0005;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        err_clr2 = 1'b0;
        chk("clr_with_err", 32'(err_count2), 1);
        chk("clr_with_err_flag", 32'(out_err2), 1);

        // 3-bit binary instance
        in_valid3 = 1'b1; mode3 = 1'b0; in_data3 = 8'hF7;
        @(posedge clk);
        #1;
        chk("w3_valid", 32'(out_valid3), 1);
        chk("w3_onehot", 32'(out_onehot3), 32'h80);
        chk("w3_bin", 32'(out_bin3), 7);
        chk("w3_err", 32'(out_err3), 0);
        mode3 = 1'b1; in_data3 = 8'h24;
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
        chk("w3_dec_onehot", 32'(out_onehot3), 32'h04);
        chk("w3_dec_bin", 32'(out_bin3), 2);
        chk("w3_dec_err", 32'(out_err3), 1);
        chk("w3_err_count", 32'(err_count3), 1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
